// File: rtl/cache_2way_wb.sv
// cache_2way_wb: 2-way set-associative, write-back, write-allocate cache
// sitting between a single-word CPU port and a word-wide backing memory.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   cpu_req/cpu_we        CPU access request (held until cpu_ready), 1 = write
//   cpu_addr/cpu_wdata    word address {tag, index, offset} and write data
//   cpu_ready/cpu_rdata   one-cycle completion pulse and read data
//   mem_req/mem_we        memory word request (held until mem_ack), 1 = write-back
//   mem_addr/mem_wdata    memory word address and write-back data
//   mem_ack/mem_rdata     memory completion pulse and refill data
//
// A miss first writes the dirty victim line back word by word (if needed),
// then refills the line word by word, then replays the original access as a
// hit in DONE. All CPU/memory facing outputs are registered.
module cache_2way_wb #(
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
  localparam int SETS      = 1 << INDEX_W;
  localparam int LINES     = 2 * SETS;
  localparam int WORDS_ALL = LINES << OFFSET_W;
  localparam int WA_W      = 1 + INDEX_W + OFFSET_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, DONE} state_t;

  state_t              state_q, state_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic                victim_q, victim_d;
  logic                cpu_ready_q, cpu_ready_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  // Storage: line words addressed {way, index, offset}, tags {way, index}.
  logic [DATA_W-1:0] data_mem [WORDS_ALL];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [1:0]        valid_q  [SETS];
  logic [1:0]        dirty_q  [SETS];
  logic [SETS-1:0]   lru_q;

  logic [TAG_W-1:0]    cpu_tag;
  logic [INDEX_W-1:0]  cpu_idx;
  logic [OFFSET_W-1:0] cpu_off;
  logic [OFFSET_W-1:0] cnt_inc;
  logic                cnt_last;
  logic                hit0, hit1, hit, hit_way;
  logic                miss_victim, access_way, evict_way, evict_dirty;
  logic [TAG_W-1:0]    evict_tag;
  logic [WA_W-1:0]     rd_addr, wr_addr;
  logic [DATA_W-1:0]   rd_word, wr_data;
  logic                wr_en, fill_en, dirty_set, touch_en;

  assign cpu_tag  = cpu_addr[ADDR_W-1 -: TAG_W];
  assign cpu_idx  = cpu_addr[OFFSET_W +: INDEX_W];
  assign cpu_off  = cpu_addr[OFFSET_W-1:0];
  assign cnt_inc  = cnt_q + OFFSET_W'(1);
  assign cnt_last = &cnt_q;

  assign hit0    = valid_q[cpu_idx][0] && (tag_mem[{1'b0, cpu_idx}] == cpu_tag);
  assign hit1    = valid_q[cpu_idx][1] && (tag_mem[{1'b1, cpu_idx}] == cpu_tag);
  assign hit     = hit0 | hit1;
  assign hit_way = ~hit0;  // way 0 wins if both ways claim the tag

  // Fill an empty way first (way 0 before way 1), otherwise evict the LRU way.
  assign miss_victim = !valid_q[cpu_idx][0] ? 1'b0 :
                       !valid_q[cpu_idx][1] ? 1'b1 : lru_q[cpu_idx];
  assign access_way  = (state_q == IDLE) ? hit_way : victim_q;
  assign evict_way   = (state_q == IDLE) ? miss_victim : victim_q;
  assign evict_tag   = tag_mem[{evict_way, cpu_idx}];
  assign evict_dirty = valid_q[cpu_idx][miss_victim] && dirty_q[cpu_idx][miss_victim];

  // Read address is resolved separately so the read word feeds the FSM
  // without a combinational path back through it.
  always_comb begin
    rd_addr = {access_way, cpu_idx, cpu_off};
    if (state_q == IDLE && !hit) begin
      rd_addr = {miss_victim, cpu_idx, {OFFSET_W{1'b0}}};
    end else if (state_q == WRITEBACK) begin
      rd_addr = {victim_q, cpu_idx, cnt_inc};
    end
  end
  assign rd_word = data_mem[rd_addr];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    victim_d    = victim_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_en       = 1'b0;
    wr_addr     = {access_way, cpu_idx, cpu_off};
    wr_data     = cpu_wdata;
    fill_en     = 1'b0;
    dirty_set   = 1'b0;
    touch_en    = 1'b0;
    case (state_q)
      IDLE: begin
        // cpu_ready_q high means the CPU is still holding the request it
        // just got an answer for; it must not be served twice.
        if (cpu_req && !cpu_ready_q) begin
          if (hit) begin
            cpu_ready_d = 1'b1;
            cpu_rdata_d = rd_word;
            wr_en       = cpu_we;
            dirty_set   = cpu_we;
            touch_en    = 1'b1;
          end else begin
            victim_d  = miss_victim;
            cnt_d     = '0;
            mem_req_d = 1'b1;
            if (evict_dirty) begin
              state_d     = WRITEBACK;
              mem_we_d    = 1'b1;
              mem_addr_d  = {evict_tag, cpu_idx, {OFFSET_W{1'b0}}};
              mem_wdata_d = rd_word;
            end else begin
              state_d    = REFILL;
              mem_we_d   = 1'b0;
              mem_addr_d = {cpu_tag, cpu_idx, {OFFSET_W{1'b0}}};
            end
          end
        end
      end
      WRITEBACK: begin
        if (mem_req_q && mem_ack) begin
          if (cnt_last) begin
            cnt_d      = '0;
            state_d    = REFILL;
            mem_we_d   = 1'b0;
            mem_addr_d = {cpu_tag, cpu_idx, {OFFSET_W{1'b0}}};
          end else begin
            cnt_d       = cnt_inc;
            mem_addr_d  = {evict_tag, cpu_idx, cnt_inc};
            mem_wdata_d = rd_word;
          end
        end
      end
      REFILL: begin
        if (mem_req_q && mem_ack) begin
          wr_en   = 1'b1;
          wr_addr = {victim_q, cpu_idx, cnt_q};
          wr_data = mem_rdata;
          if (cnt_last) begin
            cnt_d     = '0;
            mem_req_d = 1'b0;
            fill_en   = 1'b1;
            state_d   = DONE;
          end else begin
            cnt_d      = cnt_inc;
            mem_addr_d = {cpu_tag, cpu_idx, cnt_inc};
          end
        end
      end
      DONE: begin
        cpu_ready_d = 1'b1;
        cpu_rdata_d = rd_word;
        wr_en       = cpu_we;
        dirty_set   = cpu_we;
        touch_en    = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      victim_q    <= 1'b0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      lru_q       <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= 2'b00;
        dirty_q[s] <= 2'b00;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      victim_q    <= victim_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (fill_en) begin
        valid_q[cpu_idx][victim_q] <= 1'b1;
        dirty_q[cpu_idx][victim_q] <= 1'b0;
      end
      if (dirty_set) dirty_q[cpu_idx][access_way] <= 1'b1;
      if (touch_en) lru_q[cpu_idx] <= ~access_way;
    end
  end

  // Line data and tags carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (wr_en) data_mem[wr_addr] <= wr_data;
    if (fill_en) tag_mem[{victim_q, cpu_idx}] <= cpu_tag;
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cache_2way_wb.sv
// tb_cache_2way_wb: self-checking bench for cache_2way_wb. A behavioural
// cache model (per-set ways, LRU, backing-memory image) predicts each
// access's read data, memory transfer sequence and latency; a memory
// responder checks every memory transfer against that prediction.
module tb_cache_2way_wb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [16:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cache_2way_wb #(.ADDR_W(17), .DATA_W(32), .INDEX_W(6), .OFFSET_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        we;
    logic [16:0] addr;
    logic [31:0] wdata;
  } mem_op_t;

  mem_op_t     exp_q[$];
  int          mem_delay = 0;
  logic        rst_at_edge = 1'b0;
  logic [31:0] mem_img [int];
  logic [31:0] mdl_mem [int];

  // Reference cache state.
  bit          m_valid [2][64];
  bit          m_dirty [2][64];
  int          m_tag   [2][64];
  logic [31:0] m_data  [2][64][4];
  int          m_lru   [64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [31:0] fill_val(input int a);
    return 32'hC0DE0000 ^ a;
  endfunction

  function automatic logic [31:0] img_read(input int a);
    if (mem_img.exists(a)) return mem_img[a];
    return fill_val(a);
  endfunction

  function automatic logic [31:0] mdl_read(input int a);
    if (mdl_mem.exists(a)) return mdl_mem[a];
    return fill_val(a);
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 64; s++) begin
        m_valid[w][s] = 1'b0;
        m_dirty[w][s] = 1'b0;
      end
    for (int s = 0; s < 64; s++) m_lru[s] = 0;
  endtask

  // Predicts one access: queues expected memory words and returns read data.
  task automatic model_access(input logic we, input logic [16:0] addr, input logic [31:0] wd,
                              output logic [31:0] rd, output int nwords);
    int tag, idx, off, way, v, a;
    tag = int'(addr) >> 8;
    idx = (int'(addr) >> 2) & 63;
    off = int'(addr) & 3;
    way = -1;
    nwords = 0;
    for (int w = 1; w >= 0; w--)
      if (m_valid[w][idx] && m_tag[w][idx] == tag) way = w;
    if (way < 0) begin
      if (!m_valid[0][idx]) v = 0;
      else if (!m_valid[1][idx]) v = 1;
      else v = m_lru[idx];
      if (m_valid[v][idx] && m_dirty[v][idx]) begin
        for (int o = 0; o < 4; o++) begin
          a = (m_tag[v][idx] << 8) | (idx << 2) | o;
          exp_q.push_back(mem_op_t'{we: 1'b1, addr: 17'(a), wdata: m_data[v][idx][o]});
          mdl_mem[a] = m_data[v][idx][o];
          nwords++;
        end
      end
      for (int o = 0; o < 4; o++) begin
        a = (tag << 8) | (idx << 2) | o;
        exp_q.push_back(mem_op_t'{we: 1'b0, addr: 17'(a), wdata: 32'h0});
        m_data[v][idx][o] = mdl_read(a);
        nwords++;
      end
      m_valid[v][idx] = 1'b1;
      m_dirty[v][idx] = 1'b0;
      m_tag[v][idx]   = tag;
      way = v;
    end
    if (we) begin
      m_data[way][idx][off] = wd;
      m_dirty[way][idx]     = 1'b1;
    end
    rd = m_data[way][idx][off];
    m_lru[idx] = 1 - way;
  endtask

  always @(posedge clk) rst_at_edge = rst_n;

  // Backing memory: a word transfer starts the first cycle mem_req is seen,
  // is acked mem_delay+1 cycles later, and must hold its fields meanwhile.
  bit      busy = 1'b0;
  int      wcnt = 0;
  mem_op_t cur;
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (!rst_at_edge) begin
      busy = 1'b0;
    end else if (mem_req) begin
      if (!busy) begin
        busy = 1'b1;
        wcnt = mem_delay;
        cur  = mem_op_t'{we: mem_we, addr: mem_addr, wdata: mem_wdata};
        if (exp_q.size() == 0) begin
          fail_now($sformatf("mem_unexpected we=%0b addr=%05h", mem_we, mem_addr));
        end else begin
          mem_op_t e;
          e = exp_q.pop_front();
          chk("mem_we", 64'(mem_we), 64'(e.we));
          chk("mem_addr", 64'(mem_addr), 64'(e.addr));
          if (e.we) chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
        end
      end else begin
        chk("mem_hold", {mem_we, mem_addr, (cur.we ? mem_wdata : 32'h0)},
            {cur.we, cur.addr, (cur.we ? cur.wdata : 32'h0)});
        if (wcnt == 0) begin
          mem_ack = 1'b1;
          if (cur.we) mem_img[int'(cur.addr)] = cur.wdata;
          else mem_rdata = img_read(int'(cur.addr));
          busy = 1'b0;
        end else begin
          wcnt--;
        end
      end
    end else if (busy) begin
      fail_now("mem_req_dropped");
      busy = 1'b0;
    end
  end

  // One CPU access, started and ended on a falling edge.
  task automatic do_access(input logic we, input logic [16:0] addr, input logic [31:0] wd,
                           input int d, output logic [31:0] rd_act, output int nw, output int lat);
    logic [31:0] exp_rd;
    bit got;
    int exp_lat;
    mem_delay = d;
    model_access(we, addr, wd, exp_rd, nw);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = addr;
    cpu_wdata = wd;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 1000) begin
      @(negedge clk);
      lat++;
      if (cpu_ready) got = 1'b1;
    end
    rd_act = cpu_rdata;
    cpu_req = 1'b0;
    if (!got) begin
      fail_now($sformatf("ready_timeout addr=%05h", addr));
      exp_q.delete();
    end else begin
      exp_lat = (nw == 0) ? 1 : 2 + nw * (d + 2);
      chk("latency", 64'(lat), 64'(exp_lat));
      if (!we) chk("rdata", 64'(rd_act), 64'(exp_rd));
      chk("mem_words_done", 64'(exp_q.size()), 64'd0);
    end
    $display("access %s addr=%05h wdata=%08h delay=%0d words=%0d lat=%0d rdata=%08h",
             we ? "WR" : "RD", addr, wd, d, nw, lat, rd_act);
    @(negedge clk);
    chk("ready_pulse", 64'(cpu_ready), 64'd0);
    chk("idle_mem_req", 64'(mem_req), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int nw, lat;
    bit found;
    logic [16:0] a;

    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", 64'(cpu_ready), 64'd0);
    chk("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold read, write hit, reread.
    do_access(1'b0, 17'h1380B, 32'h0, 0, rd, nw, lat);
    chk("lit_cold_words", 64'(nw), 64'd4);
    chk("lit_cold_rdata", 64'(rd), 64'hC0DF380B);
    chk("lit_cold_lat", 64'(lat), 64'd10);
    do_access(1'b1, 17'h1380B, 32'h0F0F0F0F, 0, rd, nw, lat);
    chk("lit_wr_hit_lat", 64'(lat), 64'd1);
    do_access(1'b0, 17'h1380B, 32'h0, 0, rd, nw, lat);
    chk("lit_reread", 64'(rd), 64'h0F0F0F0F);
    // Second tag in the same set fills way 1, first tag still resident.
    do_access(1'b0, 17'h1B80B, 32'h0, 0, rd, nw, lat);
    chk("lit_way1_words", 64'(nw), 64'd4);
    do_access(1'b0, 17'h1380B, 32'h0, 0, rd, nw, lat);
    chk("lit_way0_still", 64'(rd), 64'h0F0F0F0F);
    do_access(1'b0, 17'h1B80B, 32'h0, 0, rd, nw, lat);
    chk("lit_way1_hit", 64'(nw), 64'd0);
    // Third tag evicts the dirty way 0.
    do_access(1'b0, 17'h0380B, 32'h0, 0, rd, nw, lat);
    chk("lit_evict_words", 64'(nw), 64'd8);
    chk("lit_wb_word3", 64'(img_read(32'h1380B)), 64'h0F0F0F0F);
    chk("lit_wb_word0", 64'(img_read(32'h13808)), 64'hC0DF3808);
    do_access(1'b0, 17'h1380B, 32'h0, 0, rd, nw, lat);
    chk("lit_after_evict_words", 64'(nw), 64'd4);
    chk("lit_after_evict_rdata", 64'(rd), 64'h0F0F0F0F);

    // Reset during the second refill word.
    mem_delay = 0;
    model_access(1'b0, 17'h1B80B, 32'h0, rd, nw);
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 17'h1B80B;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_addr == 17'h1B809) found = 1'b1;
    end
    chk("rst_second_word_seen", 64'(found), 64'd1);
    rst_n = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("rst_abort_mem_req", 64'(mem_req), 64'd0);
    chk("rst_abort_no_ready", 64'(cpu_ready), 64'd0);
    exp_q.delete();
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_no_ready", 64'(cpu_ready), 64'd0);
    do_access(1'b0, 17'h1B80B, 32'h0, 0, rd, nw, lat);
    chk("lit_post_rst_words", 64'(nw), 64'd4);
    chk("lit_post_rst_rdata", 64'(rd), 64'hC0DFB80B);

    // Slow memory: 5 extra cycles per word.
    do_access(1'b0, 17'h05030, 32'h0, 5, rd, nw, lat);
    chk("lit_slow_lat", 64'(lat), 64'd30);
    chk("lit_slow_rdata", 64'(rd), 64'hC0DE5030);

    // Random traffic on two sets with four competing tags.
    for (int i = 0; i < 200; i++) begin
      a = {9'($urandom_range(0, 3)), 6'($urandom_range(10, 11)), 2'($urandom_range(0, 3))};
      do_access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), rd, nw, lat);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
